magnetron_ctrl: RTL and testbench



---
 rtl/magnetron_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_magnetron_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/magnetron_ctrl.sv
// -----------------------------------------------------------------------------
// magnetron_ctrl
// Clocked microwave-oven magnetron controller: cook-time countdown, power-level
// duty cycling and pause/resume, sitting between the front-panel buttons/door
// switch and the magnetron drive.
//
// Build option: define MAG_POWER_EN to enable power-level duty cycling. When it
// is left undefined the magnetron is driven for the whole of COOK and the
// power_in / duty counter logic is not built.
//
// Parameters
//   TIME_W    : width of the cook time in seconds
//   TICK_DIV  : clk cycles per one-second tick (>= 2)
//   POWER_MAX : full-power level and duty window length in ticks
//   PW_W      : width of the power level (must hold POWER_MAX)
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   startn            : start button, active low, acts on its falling edge
//   stopn, clearn     : stop / clear buttons, active low, level sensitive
//   door_closed       : 1 = door closed
//   time_load         : one-cycle strobe loading time_in and power_in
//   time_in, power_in : cook time (s) and power level (0..POWER_MAX)
//   mag_on            : registered magnetron enable
//   remaining         : seconds left
//   done              : high while in DONE
//   state             : IDLE=0, COOK=1, PAUSE=2, DONE=3
// -----------------------------------------------------------------------------
module magnetron_ctrl #(
    parameter int TIME_W    = 12,
    parameter int TICK_DIV  = 50_000_000,
    parameter int POWER_MAX = 10,
    parameter int PW_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic              time_load,
    input  logic [TIME_W-1:0] time_in,
    input  logic [PW_W-1:0]   power_in,
    output logic              mag_on,
    output logic [TIME_W-1:0] remaining,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int             PS_W      = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] TICK_LAST = PS_W'(TICK_DIV - 1);

    state_t              state_r;
    logic [TIME_W-1:0]   remaining_r;
    logic [PS_W-1:0]     presc_r;
    logic                startn_q_r;
    logic                mag_on_r;
    logic                done_r;

    logic                start_ev_s;
    logic                rem_nz_s;
    // Duty condition for: staying on the current duty slot, the slot after a
    // tick, and a fresh start (duty count 0).
    logic                duty_now_s;
    logic                duty_tick_s;
    logic                duty_start_s;

    assign start_ev_s = startn_q_r & ~startn;
    assign rem_nz_s   = (remaining_r != {TIME_W{1'b0}});

`ifdef MAG_POWER_EN
    logic [PW_W-1:0]     power_r;
    logic [PW_W-1:0]     duty_r;
    logic [PW_W-1:0]     duty_inc_s;
    logic [PW_W-1:0]     pow_clamp_s;

    assign duty_inc_s   = (duty_r == PW_W'(POWER_MAX - 1)) ? {PW_W{1'b0}} : (duty_r + PW_W'(1));
    assign pow_clamp_s  = (power_in > PW_W'(POWER_MAX)) ? PW_W'(POWER_MAX) : power_in;
    assign duty_now_s   = (duty_r < power_r);
    assign duty_tick_s  = (duty_inc_s < power_r);
    assign duty_start_s = (power_r != {PW_W{1'b0}});
`else
    logic                unused_power_s;

    assign unused_power_s = ^{power_in, PW_W'(POWER_MAX)};
    assign duty_now_s     = 1'b1;
    assign duty_tick_s    = 1'b1;
    assign duty_start_s   = 1'b1;
`endif

    // Controller FSM with its counters; mag_on/done default low and are
    // raised only on paths whose next state is COOK/DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            remaining_r <= {TIME_W{1'b0}};
            presc_r     <= {PS_W{1'b0}};
            startn_q_r  <= 1'b1;
            mag_on_r    <= 1'b0;
            done_r      <= 1'b0;
`ifdef MAG_POWER_EN
            power_r     <= PW_W'(POWER_MAX);
            duty_r      <= {PW_W{1'b0}};
`endif
        end else begin
            startn_q_r <= startn;
            mag_on_r   <= 1'b0;
            done_r     <= 1'b0;
            if (!clearn) begin
                state_r     <= IDLE;
                remaining_r <= {TIME_W{1'b0}};
                presc_r     <= {PS_W{1'b0}};
`ifdef MAG_POWER_EN
                power_r     <= PW_W'(POWER_MAX);
                duty_r      <= {PW_W{1'b0}};
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        // A held stop button outranks a start press.
                        if (start_ev_s && stopn && door_closed && rem_nz_s) begin
                            state_r  <= COOK;
                            presc_r  <= {PS_W{1'b0}};
                            mag_on_r <= duty_start_s;
`ifdef MAG_POWER_EN
                            duty_r   <= {PW_W{1'b0}};
`endif
                        end else if (time_load) begin
                            remaining_r <= time_in;
`ifdef MAG_POWER_EN
                            power_r     <= pow_clamp_s;
`endif
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    COOK: begin
                        if (!stopn || !door_closed) begin
                            // Counters freeze; resume continues from here.
                            state_r <= PAUSE;
                        end else if (presc_r == TICK_LAST) begin
                            presc_r <= {PS_W{1'b0}};
`ifdef MAG_POWER_EN
                            duty_r  <= duty_inc_s;
`endif
                            if (remaining_r <= TIME_W'(1)) begin
                                remaining_r <= {TIME_W{1'b0}};
                                state_r     <= DONE;
                                done_r      <= 1'b1;
                            end else begin
                                remaining_r <= remaining_r - TIME_W'(1);
                                mag_on_r    <= duty_tick_s;
                            end
                        end else begin
                            presc_r  <= presc_r + PS_W'(1);
                            mag_on_r <= duty_now_s;
                        end
                    end
                    PAUSE: begin
                        if (!stopn) begin
                            state_r     <= IDLE;
                            remaining_r <= {TIME_W{1'b0}};
                        end else if (start_ev_s && door_closed) begin
                            state_r  <= COOK;
                            mag_on_r <= duty_now_s;
                        end else begin
                            state_r <= PAUSE;
                        end
                    end
                    DONE: begin
                        if (!stopn || !door_closed) begin
                            state_r <= IDLE;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mag_on    = mag_on_r;
    assign remaining = remaining_r;
    assign done      = done_r;
    assign state     = state_r;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// -----------------------------------------------------------------------------
// tb_magnetron_ctrl
// Self-checking bench for magnetron_ctrl (TICK_DIV=4, POWER_MAX=10). A
// behavioural model tracks total cook cycles ("burn") and derives the tick,
// duty slot and countdown from it arithmetically. Directed scenarios are
// followed by randomized button/door/load stimulus.
// -----------------------------------------------------------------------------
module tb_magnetron_ctrl;

    localparam int TIME_W    = 12;
    localparam int TICK_DIV  = 4;
    localparam int POWER_MAX = 10;
    localparam int PW_W      = 4;

    localparam int S_IDLE  = 0;
    localparam int S_COOK  = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              startn = 1'b1;
    logic              stopn = 1'b1;
    logic              clearn = 1'b1;
    logic              door_closed = 1'b1;
    logic              time_load = 1'b0;
    logic [TIME_W-1:0] time_in = '0;
    logic [PW_W-1:0]   power_in = '0;
    logic              mag_on;
    logic [TIME_W-1:0] remaining;
    logic              done;
    logic [1:0]        state;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int m_state;
    int m_rem;
    int m_pow;
    int m_burn;
    bit m_prev_startn;
    bit m_mag;
    bit m_done;

    magnetron_ctrl #(
        .TIME_W(TIME_W), .TICK_DIV(TICK_DIV), .POWER_MAX(POWER_MAX), .PW_W(PW_W)
    ) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .time_load(time_load), .time_in(time_in),
        .power_in(power_in), .mag_on(mag_on), .remaining(remaining), .done(done),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit duty_on(input int burn, input int pow);
`ifdef MAG_POWER_EN
        return ((burn / TICK_DIV) % POWER_MAX) < pow;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_rem = 0; m_pow = POWER_MAX; m_burn = 0;
        m_prev_startn = 1'b1; m_mag = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step();
        bit start_ev;
        start_ev = m_prev_startn && !startn;
        m_prev_startn = startn;
        if (!clearn) begin
            m_state = S_IDLE; m_rem = 0; m_pow = POWER_MAX; m_burn = 0;
        end else begin
            case (m_state)
                S_IDLE: begin
                    if (start_ev && stopn && door_closed && m_rem != 0) begin
                        m_state = S_COOK; m_burn = 0;
                    end else if (time_load) begin
                        m_rem = int'(time_in);
                        m_pow = (int'(power_in) > POWER_MAX) ? POWER_MAX : int'(power_in);
                    end
                end
                S_COOK: begin
                    if (!stopn || !door_closed) m_state = S_PAUSE;
                    else begin
                        m_burn++;
                        if (m_burn % TICK_DIV == 0) begin
                            if (m_rem <= 1) begin m_rem = 0; m_state = S_DONE; end
                            else m_rem--;
                        end
                    end
                end
                S_PAUSE: begin
                    if (!stopn) begin m_state = S_IDLE; m_rem = 0; end
                    else if (start_ev && door_closed) m_state = S_COOK;
                end
                default: begin
                    if (!stopn || !door_closed) m_state = S_IDLE;
                end
            endcase
        end
        m_mag  = (m_state == S_COOK) && duty_on(m_burn, m_pow);
        m_done = (m_state == S_DONE);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_eq("state", int'(state), m_state);
        check_eq("remaining", int'(remaining), m_rem);
        check_eq("mag_on", int'(mag_on), int'(m_mag));
        check_eq("done", int'(done), int'(m_done));
    endtask

    task automatic load(input int t, input int p);
        time_in = TIME_W'(t); power_in = PW_W'(p); time_load = 1'b1;
        step();
        time_load = 1'b0;
    endtask

    task automatic press();
        startn = 1'b0;
        step();
        startn = 1'b1;
    endtask

    initial begin
        int cnt;
        int exp_hi;
        model_reset();
        #23;
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_remaining", int'(remaining), 0);
        check_eq("rst_mag_on", int'(mag_on), 0);
        check_eq("rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: plain cook to done
        load(3, 10);
        press();
        cnt = int'(mag_on);
        for (int i = 0; i < 15; i++) begin
            step();
            cnt += int'(mag_on);
        end
        check_eq("t1_mag_cycles", cnt, 12);
        check_eq("t1_done", int'(done), 1);

        // 2: duty cycling
        clearn = 1'b0; step(); clearn = 1'b1;
        load(10, 3);
        press();
        cnt = int'(mag_on);
        for (int i = 0; i < 44; i++) begin
            step();
            cnt += int'(mag_on);
        end
`ifdef MAG_POWER_EN
        exp_hi = 12;
`else
        exp_hi = 40;
`endif
        check_eq("t2_mag_cycles", cnt, exp_hi);
        check_eq("t2_state", int'(state), S_DONE);

        // 3: door pause and resume
        clearn = 1'b0; step(); clearn = 1'b1;
        load(8, 10);
        press();
        for (int i = 0; i < 100 && remaining != TIME_W'(5); i++) step();
        check_eq("t3_reach5", int'(remaining), 5);
        step(); step();
        door_closed = 1'b0;
        step();
        check_eq("t3_pause", int'(state), S_PAUSE);
        check_eq("t3_mag_off", int'(mag_on), 0);
        check_eq("t3_hold5", int'(remaining), 5);
        door_closed = 1'b1;
        step();
        press();
        cnt = 0;
        for (int i = 0; i < 60 && state != 2'd3; i++) begin
            step();
            cnt++;
        end
        check_eq("t3_resume_cycles", cnt, 18);

        // 4: rejected starts
        clearn = 1'b0; step(); clearn = 1'b1;
        door_closed = 1'b0;
        load(5, 10);
        press();
        check_eq("t4_door_open", int'(state), S_IDLE);
        door_closed = 1'b1;
        clearn = 1'b0; step(); clearn = 1'b1;
        press();
        check_eq("t4_rem_zero", int'(state), S_IDLE);

        // 5: simultaneous events
        load(1, 10);
        press();
        step(); step(); step();
        stopn = 1'b0;
        step();
        check_eq("t5_stop_final", int'(state), S_PAUSE);
        check_eq("t5_rem1", int'(remaining), 1);
        clearn = 1'b0;
        step();
        clearn = 1'b1; stopn = 1'b1;
        check_eq("t5_clear_stop", int'(state), S_IDLE);
        check_eq("t5_clear_rem", int'(remaining), 0);

        // 6: async reset mid-cook
        load(6, 10);
        press();
        step(); step();
        #2 rst = 1'b1;
        #1;
        check_eq("t6_mag_async", int'(mag_on), 0);
        check_eq("t6_state_async", int'(state), 0);
        check_eq("t6_rem_async", int'(remaining), 0);
        model_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_eq("t6_no_restart", int'(state), S_IDLE);

        // randomized stimulus
        for (int i = 0; i < 2500; i++) begin
            clearn    = ($urandom_range(0, 99) != 0);
            stopn     = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 29) == 0) door_closed = ~door_closed;
            startn    = ($urandom_range(0, 5) != 0);
            time_load = ($urandom_range(0, 9) == 0);
            time_in   = TIME_W'($urandom_range(0, 6));
            power_in  = PW_W'($urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
